// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/load controller for a downstream counter.
// A prescaler divides the clock into one-cycle enb pulses while running.
// A valid/ready load port produces a one-cycle load strobe with data_in.
// Optional feature: define COUNTER_CTRL_TICK_CNT_EN to add the 16-bit
// saturating tick_cnt output, which counts enb pulses.
module counter_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 asyn_rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [DIV_WIDTH-1:0] div_val,
  input  logic                 ld_valid,
  input  logic [WIDTH-1:0]     ld_data,
  output logic                 ld_ready,
  output logic                 enb,
  output logic                 load,
  output logic [WIDTH-1:0]     data_in,
`ifdef COUNTER_CTRL_TICK_CNT_EN
  output logic                 running,
  output logic [15:0]          tick_cnt
`else
  output logic                 running
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] presc;
  // Mode that LOAD returns to: 1 = RUN, 0 = IDLE.
  logic                 ret_run;

  logic handshake;
  logic start_req;
  logic match;

  // Request decoding: stop always dominates start; the handshake uses the
  // registered ld_ready, which is low only while in LOAD.
  always_comb begin
    handshake = ld_valid & ld_ready;
    start_req = start & ~stop;
    match     = (presc == div_val);
  end

  // Control FSM with registered outputs; a load handshake takes priority
  // over stop and over a prescaler match in the same cycle.
  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      state    <= IDLE;
      presc    <= '0;
      ret_run  <= 1'b0;
      enb      <= 1'b0;
      load     <= 1'b0;
      data_in  <= '0;
      running  <= 1'b0;
      ld_ready <= 1'b0;
    end else begin
      enb      <= 1'b0;
      load     <= 1'b0;
      ld_ready <= 1'b1;
      case (state)
        IDLE: begin
          if (handshake) begin
            state    <= LOAD;
            load     <= 1'b1;
            data_in  <= ld_data;
            ret_run  <= 1'b0;
            running  <= 1'b0;
            ld_ready <= 1'b0;
          end else if (start_req) begin
            state   <= RUN;
            presc   <= '0;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (handshake) begin
            // A concurrent stop is remembered so LOAD exits to IDLE.
            state    <= LOAD;
            load     <= 1'b1;
            data_in  <= ld_data;
            ret_run  <= ~stop;
            running  <= 1'b1;
            ld_ready <= 1'b0;
          end else if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (match) begin
            enb   <= 1'b1;
            presc <= '0;
          end else begin
            presc <= presc + DIV_WIDTH'(1);
          end
        end
        LOAD: begin
          presc <= '0;
          if (ret_run && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end else begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef COUNTER_CTRL_TICK_CNT_EN
  // Count enb pulses, saturating at all-ones; only reset clears it.
  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      tick_cnt <= '0;
    end else if (enb && (tick_cnt != '1)) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the width of the load-data and counter-data paths.
REQ-002 The block SHALL have parameter DIV_WIDTH, default 8, giving the width of the prescaler divide value.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port asyn_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit: request to enter counting mode.
REQ-006 The block SHALL have port stop, input, 1 bit: request to leave counting mode.
REQ-007 The block SHALL have port div_val, input, DIV_WIDTH bits: one enable tick every div_val+1 cycles while running.
REQ-008 The block SHALL have port ld_valid, input, 1 bit: a load request is present.
REQ-009 The block SHALL have port ld_data, input, WIDTH bits: load value, qualified by ld_valid.
REQ-010 The block SHALL have port ld_ready, output, 1 bit: the block accepts a load request this cycle.
REQ-011 The block SHALL have port enb, output, 1 bit: one-cycle enable pulse to the downstream counter.
REQ-012 The block SHALL have port load, output, 1 bit: one-cycle synchronous load strobe to the downstream counter.
REQ-013 The block SHALL have port data_in, output, WIDTH bits: load value to the downstream counter, valid while load=1.
REQ-014 The block SHALL have port running, output, 1 bit: high while in counting mode, including a load cycle entered from RUN.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and LOAD, and all outputs SHALL be registered.
REQ-016 In IDLE, start=1 with stop=0 SHALL move the FSM to RUN and clear the prescaler to 0.
REQ-017 In RUN, stop=1 SHALL move the FSM to IDLE; if start and stop are both 1, stop SHALL win in every state.
REQ-018 In RUN, the prescaler SHALL increment each cycle; when it equals div_val, enb SHALL be 1 for exactly the next cycle and the prescaler SHALL return to 0.
REQ-019 With div_val=0, enb SHALL be high on every RUN cycle.
REQ-020 A div_val change while running SHALL take effect at the next compare; if the prescaler already exceeds the new div_val, it SHALL wrap modulo 2^DIV_WIDTH before matching.
REQ-021 ld_ready SHALL be 1 in IDLE and RUN and 0 in LOAD.
REQ-022 A handshake is ld_valid and ld_ready both 1 on a clock edge; it SHALL capture ld_data and move the FSM to LOAD.
REQ-023 In LOAD, load SHALL be 1 and data_in SHALL hold the captured value for exactly one cycle, with enb forced to 0.
REQ-024 LOAD SHALL return to the mode held at the handshake, RUN or IDLE, and SHALL clear the prescaler to 0.
REQ-025 A stop during LOAD SHALL make LOAD return to IDLE; a start during LOAD SHALL be ignored.
REQ-026 A handshake in the same cycle as stop, or as a prescaler match, SHALL give the load priority: no enb pulse that cycle, and the stop is recorded for LOAD's exit.
REQ-027 Back-to-back loads SHALL be accepted at most every second cycle.
REQ-028 data_in SHALL retain its last loaded value while load=0.

Reset
REQ-029 While asyn_rst=1, the block SHALL asynchronously force state IDLE, prescaler 0, enb 0, load 0, data_in 0, running 0 and ld_ready 0.
REQ-030 ld_ready SHALL go to 1 on the first clock edge after asyn_rst falls.
REQ-031 A reset asserted during LOAD SHALL abort the load; no load pulse SHALL appear after reset release.

Configuration
REQ-032 With macro COUNTER_CTRL_TICK_CNT_EN defined, the block SHALL add output tick_cnt, 16 bits, counting enb pulses, saturating at 0xFFFF, and cleared only by reset.
REQ-033 Without COUNTER_CTRL_TICK_CNT_EN, the tick_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-034 Reset, then start=1 for 1 cycle with div_val=3 -> enb pulses on cycles 4, 8 and 12 after entering RUN; running=1.
REQ-035 In RUN, ld_valid=1 with ld_data=4'hA for 1 cycle -> load=1, data_in=4'hA for 1 cycle, enb=0 that cycle, ld_ready=0 that cycle, then next enb pulse div_val+1 cycles after LOAD exits.
REQ-036 start=1 and stop=1 together in IDLE -> remains IDLE, no enb; the same in RUN -> IDLE next cycle.
REQ-037 ld_valid held at 1 with ld_data=4'h5 then 4'h6 -> load pulses on alternate cycles, data_in 5 then 6, state stays IDLE.
REQ-038 asyn_rst pulsed mid-LOAD (asynchronous to clk) -> all outputs 0 immediately, no load after release, ld_ready=1 one edge later.
REQ-039 With COUNTER_CTRL_TICK_CNT_EN and div_val=0, run 70000 cycles -> tick_cnt=16'hFFFF and holds.
